// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and FSM state encoding.
// Imported by axil_master and axil_slave.
package axil_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WB   = 3'd2,
        ST_RA   = 3'd3,
        ST_RD   = 3'd4,
        ST_RSP  = 3'd5
    } axil_state_t;

    // SLVERR and DECERR both have bit 1 set; OKAY and EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axil_master.sv
// AXI4-Lite initiator: single-beat user requests to AXI-Lite transactions.
// One outstanding transaction; response returned on a valid/ready channel.
module axil_master
    import axil_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 32,
    parameter int         STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  usr_req_valid,
    output logic                  usr_req_ready,
    input  logic                  usr_req_we,
    input  logic [ADDR_WIDTH-1:0] usr_req_addr,
    input  logic [DATA_WIDTH-1:0] usr_req_wdata,
    input  logic [STRB_WIDTH-1:0] usr_req_wstrb,

    output logic                  usr_rsp_valid,
    input  logic                  usr_rsp_ready,
    output logic [DATA_WIDTH-1:0] usr_rsp_rdata,
    output logic                  usr_rsp_err,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    axil_state_t           state_q;
    axil_state_t           state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  aw_done;
    logic                  w_done;

    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_wdata  = wdata_q;
    assign m_axil_wstrb  = wstrb_q;
    assign m_axil_awprot = PROT;
    assign m_axil_arprot = PROT;
    assign usr_rsp_rdata = rdata_q;
    assign usr_rsp_err   = err_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state and handshake outputs; valids decode from registers only.
    always_comb begin
        state_d        = state_q;
        usr_req_ready  = 1'b0;
        usr_rsp_valid  = 1'b0;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                usr_req_ready = 1'b1;
                if (usr_req_valid)
                    state_d = usr_req_we ? ST_WR : ST_RA;
            end
            ST_WR: begin
                m_axil_awvalid = !aw_done;
                m_axil_wvalid  = !w_done;
                if ((aw_done || m_axil_awready) &&
                    (w_done || m_axil_wready))
                    state_d = ST_WB;
            end
            ST_WB: begin
                m_axil_bready = 1'b1;
                if (m_axil_bvalid) state_d = ST_RSP;
            end
            ST_RA: begin
                m_axil_arvalid = 1'b1;
                if (m_axil_arready) state_d = ST_RD;
            end
            ST_RD: begin
                m_axil_rready = 1'b1;
                if (m_axil_rvalid) state_d = ST_RSP;
            end
            ST_RSP: begin
                usr_rsp_valid = 1'b1;
                if (usr_rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, per-channel write completion flags, response capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (usr_req_valid && usr_req_ready) begin
                addr_q  <= usr_req_addr;
                wdata_q <= usr_req_wdata;
                wstrb_q <= usr_req_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (m_axil_awvalid && m_axil_awready) aw_done <= 1'b1;
            if (m_axil_wvalid && m_axil_wready)   w_done  <= 1'b1;
            if (m_axil_bready && m_axil_bvalid) begin
                rdata_q <= '0;
                err_q   <= resp_is_err(m_axil_bresp);
            end
            if (m_axil_rready && m_axil_rvalid) begin
                rdata_q <= m_axil_rdata;
                err_q   <= resp_is_err(m_axil_rresp);
            end
        end
    end

endmodule

// File: tb/tb_axil_master.sv
// Self-checking bench for axil_master against a behavioural AXI-Lite slave
// with programmable wait states and a word-level reference memory.
module tb_axil_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        usr_req_valid = 1'b0;
    logic        usr_req_ready;
    logic        usr_req_we = 1'b0;
    logic [31:0] usr_req_addr = '0;
    logic [31:0] usr_req_wdata = '0;
    logic [3:0]  usr_req_wstrb = '0;
    logic        usr_rsp_valid;
    logic        usr_rsp_ready = 1'b0;
    logic [31:0] usr_rsp_rdata;
    logic        usr_rsp_err;

    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;

    int n_checks = 0;
    int n_errors = 0;
    int viol = 0;

    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] b_code = 2'b00, r_code = 2'b00;

    logic [31:0] smem  [16];
    logic [31:0] model [16];

    always #5 clk = ~clk;

    axil_master dut (
        .clk(clk), .rst(rst),
        .usr_req_valid(usr_req_valid), .usr_req_ready(usr_req_ready),
        .usr_req_we(usr_req_we), .usr_req_addr(usr_req_addr),
        .usr_req_wdata(usr_req_wdata), .usr_req_wstrb(usr_req_wstrb),
        .usr_rsp_valid(usr_rsp_valid), .usr_rsp_ready(usr_rsp_ready),
        .usr_rsp_rdata(usr_rsp_rdata), .usr_rsp_err(usr_rsp_err),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot),
        .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot),
        .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp),
        .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    // Behavioural slave: each ready/valid appears after its configured wait.
    bit aw_got, w_got, ar_got;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int last_aw_len, last_w_len, b_hs;
    logic [31:0] s_aw, s_wd, s_ar;
    logic [3:0]  s_ws;

    assign awready = awvalid && !aw_got && (aw_cnt >= aw_dly);
    assign wready  = wvalid && !w_got && (w_cnt >= w_dly);
    assign bvalid  = aw_got && w_got && (b_cnt >= b_dly);
    assign bresp   = b_code;
    assign arready = arvalid && !ar_got && (ar_cnt >= ar_dly);
    assign rvalid  = ar_got && (r_cnt >= r_dly);
    assign rresp   = r_code;
    assign rdata   = smem[s_ar[5:2]];

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_got <= 0; w_got <= 0; ar_got <= 0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            ar_cnt <= 0; r_cnt <= 0;
        end else begin
            if (awvalid && !aw_got) begin
                if (awready) begin
                    aw_got <= 1; s_aw <= awaddr;
                    aw_cnt <= 0; last_aw_len <= aw_cnt + 1;
                end else aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && !w_got) begin
                if (wready) begin
                    w_got <= 1; s_wd <= wdata; s_ws <= wstrb;
                    w_cnt <= 0; last_w_len <= w_cnt + 1;
                end else w_cnt <= w_cnt + 1;
            end
            if (aw_got && w_got) begin
                if (bvalid && bready) begin
                    smem[s_aw[5:2]] <= merge(smem[s_aw[5:2]], s_wd, s_ws);
                    aw_got <= 0; w_got <= 0; b_cnt <= 0;
                    b_hs <= b_hs + 1;
                end else if (!bvalid) b_cnt <= b_cnt + 1;
            end
            if (arvalid && !ar_got) begin
                if (arready) begin
                    ar_got <= 1; s_ar <= araddr; ar_cnt <= 0;
                end else ar_cnt <= ar_cnt + 1;
            end
            if (ar_got) begin
                if (rvalid && rready) begin
                    ar_got <= 0; r_cnt <= 0;
                end else if (!rvalid) r_cnt <= r_cnt + 1;
            end
        end
    end

    // Protocol monitor: pending valids hold with stable payload; rsp stable.
    bit p_aw, p_w, p_ar, p_rsp;
    logic [31:0] p_awaddr, p_wdata, p_araddr, p_rdata;
    logic [3:0]  p_wstrb;
    logic        p_err;
    always @(posedge clk) begin
        if (rst) begin
            if (p_aw && !(awvalid && awaddr == p_awaddr)) viol++;
            if (p_w && !(wvalid && wdata == p_wdata && wstrb == p_wstrb)) viol++;
            if (p_ar && !(arvalid && araddr == p_araddr)) viol++;
            if (p_rsp && !(usr_rsp_valid && usr_rsp_rdata == p_rdata &&
                           usr_rsp_err == p_err)) viol++;
            if (awprot != 3'b000 || arprot != 3'b000) viol++;
        end
        p_aw     <= rst && awvalid && !awready;
        p_w      <= rst && wvalid && !wready;
        p_ar     <= rst && arvalid && !arready;
        p_rsp    <= rst && usr_rsp_valid && !usr_rsp_ready;
        p_awaddr <= awaddr;
        p_wdata  <= wdata;
        p_wstrb  <= wstrb;
        p_araddr <= araddr;
        p_rdata  <= usr_rsp_rdata;
        p_err    <= usr_rsp_err;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, verify latency, hold and response contents.
    task automatic do_txn(input bit we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input int hold, input logic [31:0] exp_rd,
                          input bit exp_er, input int exp_lat);
        int k;
        int lat;
        @(negedge clk);
        usr_req_valid = 1; usr_req_we = we; usr_req_addr = a;
        usr_req_wdata = d; usr_req_wstrb = s;
        k = 0;
        while (!usr_req_ready && k < 100) begin @(negedge clk); k++; end
        if (!usr_req_ready) begin
            check("req_timeout", 0, 1);
            usr_req_valid = 0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        usr_req_valid = 0;
        lat = 1;
        while (!usr_rsp_valid && lat < 100) begin @(negedge clk); lat++; end
        if (!usr_rsp_valid) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        check("latency", lat, exp_lat);
        check("rdata", usr_rsp_rdata, exp_rd);
        check("err", usr_rsp_err, exp_er);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", usr_rsp_valid, 1);
            check("hold_rdata", usr_rsp_rdata, exp_rd);
            check("hold_err", usr_rsp_err, exp_er);
            check("hold_req_ready", usr_req_ready, 0);
        end
        usr_rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        usr_rsp_ready = 0;
        check("rsp_drop", usr_rsp_valid, 0);
        check("back_idle", usr_req_ready, 1);
    endtask

    // Predict from the reference memory and channel waits, then update it.
    task automatic run(input bit we, input int idx, input logic [31:0] d,
                       input logic [3:0] s, input int hold);
        logic [31:0] mask;
        logic [31:0] exp_rd;
        bit exp_er;
        int exp_lat;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (we) begin
            exp_rd  = 0;
            exp_er  = (b_code == 2'b10) || (b_code == 2'b11);
            exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
        end else begin
            exp_rd  = model[idx];
            exp_er  = (r_code == 2'b10) || (r_code == 2'b11);
            exp_lat = 3 + ar_dly + r_dly;
        end
        do_txn(we, 32'(idx * 4), d, s, hold, exp_rd, exp_er, exp_lat);
        if (we) model[idx] = (model[idx] & ~mask) | (d & mask);
    endtask

    task automatic set_dly(input int aw, input int w, input int b,
                           input int ar, input int r);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    initial begin
        int bh;
        for (int i = 0; i < 16; i++) begin smem[i] = 0; model[i] = 0; end
        b_hs = 0;
        #23;
        check("rst_req_ready", usr_req_ready, 1);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_rready", rready, 0);
        check("rst_rsp_valid", usr_rsp_valid, 0);
        check("rst_rdata", usr_rsp_rdata, 0);
        check("rst_err", usr_rsp_err, 0);
        @(negedge clk);
        rst = 1;

        run(1, 4, 32'hDEADBEEF, 4'hF, 0);
        run(0, 4, 0, 0, 0);

        set_dly(3, 0, 0, 0, 0);
        bh = b_hs;
        run(1, 8, 32'h12345678, 4'hF, 0);
        repeat (3) @(negedge clk);
        check("t3_w_len", last_w_len, 1);
        check("t3_aw_len", last_aw_len, 4);
        check("t3_b_once", b_hs - bh, 1);

        set_dly(0, 0, 0, 0, 0);
        r_code = 2'b10;
        run(0, 4, 0, 0, 5);
        r_code = 2'b00;

        set_dly(5, 5, 0, 0, 0);
        @(negedge clk);
        usr_req_valid = 1; usr_req_we = 1; usr_req_addr = 32'h10;
        usr_req_wdata = 32'hCAFEF00D; usr_req_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        usr_req_valid = 0;
        @(negedge clk);
        check("t5_aw_before", awvalid, 1);
        check("t5_w_before", wvalid, 1);
        rst = 0;
        #1;
        check("t5_aw_rst", awvalid, 0);
        check("t5_w_rst", wvalid, 0);
        check("t5_rsp_rst", usr_rsp_valid, 0);
        @(negedge clk);
        rst = 1;
        set_dly(0, 0, 0, 0, 0);
        #1;
        check("t5_req_ready", usr_req_ready, 1);
        run(0, 4, 0, 0, 0);

        repeat (150) begin
            set_dly($urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3));
            b_code = 2'($urandom_range(0, 3));
            r_code = 2'($urandom_range(0, 3));
            run(bit'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
                4'($urandom_range(0, 15)), $urandom_range(0, 2));
        end

        check("protocol", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
